// File: rtl/alu_result_drain.sv
// Drains one accumulated result from a selected ALU op cell and hands it
// to writeback over a valid/ready port, with a bounded drain time.
module alu_result_drain #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [4:0]  i_req_dest,
    output logic [1:0]  o_alu_output_op,
    output logic        o_alu_result_empty,
    input  logic        i_alu_result_valid,
    input  logic [31:0] i_alu_result,
    input  logic [4:0]  i_alu_result_flags,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_dest,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_flags,
    output logic        o_wb_timeout,
    output logic        o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic       TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT_CYCLES - 32'd1)
                                           : 8'd0;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  flags_q, flags_d;
    logic        timeout_q, timeout_d;
    logic        captured_q, captured_d;
    logic [7:0]  cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dest_d     = dest_q;
        data_d     = data_q;
        flags_d    = flags_q;
        timeout_d  = timeout_q;
        captured_d = captured_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    op_d       = i_req_op;
                    dest_d     = i_req_dest;
                    captured_d = 1'b0;
                    timeout_d  = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (i_alu_result_valid) begin
                    data_d     = i_alu_result;
                    flags_d    = i_alu_result_flags;
                    captured_d = 1'b1;
                end
                // Cell read back empty after a capture: drain is complete
                if (!i_alu_result_valid && captured_q) begin
                    state_d = S_OUT;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    state_d   = S_OUT;
                    timeout_d = 1'b1;
                    if (!captured_q && !i_alu_result_valid) begin
                        data_d  = 32'd0;
                        flags_d = 5'd0;
                    end
                end
            end
            S_OUT: begin
                if (i_wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            dest_q     <= 5'd0;
            data_q     <= 32'd0;
            flags_q    <= 5'd0;
            timeout_q  <= 1'b0;
            captured_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            flags_q    <= flags_d;
            timeout_q  <= timeout_d;
            captured_q <= captured_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_req_ready        = (state_q == S_IDLE);
    assign o_busy             = (state_q != S_IDLE);
    assign o_alu_output_op    = op_q;
    assign o_alu_result_empty = (state_q == S_DRAIN);
    assign o_wb_valid         = (state_q == S_OUT);
    assign o_wb_dest          = dest_q;
    assign o_wb_data          = data_q;
    assign o_wb_flags         = flags_q;
    assign o_wb_timeout       = timeout_q;

endmodule

// File: tb/tb_alu_result_drain.sv
// Directed bench for alu_result_drain: small ALU cell model plus a
// scoreboard of expected writebacks.
module tb_alu_result_drain;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_req_op;
    logic [4:0]  i_req_dest;
    logic [1:0]  o_alu_output_op;
    logic        o_alu_result_empty;
    logic        i_alu_result_valid;
    logic [31:0] i_alu_result;
    logic [4:0]  i_alu_result_flags;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [4:0]  o_wb_dest;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_flags;
    logic        o_wb_timeout;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    alu_result_drain #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_dest(i_req_dest),
        .o_alu_output_op(o_alu_output_op),
        .o_alu_result_empty(o_alu_result_empty),
        .i_alu_result_valid(i_alu_result_valid),
        .i_alu_result(i_alu_result),
        .i_alu_result_flags(i_alu_result_flags),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_dest(o_wb_dest), .o_wb_data(o_wb_data),
        .o_wb_flags(o_wb_flags), .o_wb_timeout(o_wb_timeout),
        .o_busy(o_busy)
    );

    // ALU op-cell model: {parity, zero, overflow, negative, carry}
    logic [31:0] cell_d [4];
    logic        cell_v [4];
    logic        wr_en;
    logic [1:0]  wr_op;
    logic [31:0] wr_val;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cell_d[i] <= 32'd0;
                cell_v[i] <= 1'b0;
            end
        end else begin
            if (o_alu_result_empty) cell_v[o_alu_output_op] <= 1'b0;
            if (wr_en) begin
                cell_d[wr_op] <= wr_val;
                cell_v[wr_op] <= 1'b1;
            end
        end
    end

    assign i_alu_result       = cell_d[o_alu_output_op];
    assign i_alu_result_valid = cell_v[o_alu_output_op];
    assign i_alu_result_flags = {^i_alu_result, i_alu_result == 32'd0,
                                 1'b0, i_alu_result[31], 1'b0};

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [4:0]  flags;
        logic        to;
    } wb_t;

    wb_t sb[$];
    int checks   = 0;
    int failures = 0;
    int n_empty;
    logic [31:0] hold_data;
    logic [4:0]  hold_flags;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cell_write(input logic [1:0] op, input logic [31:0] v);
        wr_en  = 1'b1;
        wr_op  = op;
        wr_val = v;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic request(input logic [1:0] op, input logic [4:0] dest);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_dest  = dest;
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        int k;
        n = 0;
        k = 0;
        while (!o_wb_valid && k < 40) begin
            if (o_alu_result_empty) n++;
            tick();
            k++;
        end
        check("wb_valid_seen", 64'(o_wb_valid), 64'd1);
    endtask

    task automatic cmp_wb(input string tag);
        wb_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_dest"}, 64'(o_wb_dest), 64'(e.dest));
            check({tag, "_data"}, 64'(o_wb_data), 64'(e.data));
            check({tag, "_flags"}, 64'(o_wb_flags), 64'(e.flags));
            check({tag, "_timeout"}, 64'(o_wb_timeout), 64'(e.to));
        end
    endtask

    task automatic handshake();
        i_wb_ready = 1'b1;
        tick();
        i_wb_ready = 1'b0;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_op    = 2'd0;
        i_req_dest  = 5'd0;
        i_wb_ready  = 1'b0;
        wr_en       = 1'b0;
        wr_op       = 2'd0;
        wr_val      = 32'd0;
        tick();
        tick();
        check("rst_wb_valid", 64'(o_wb_valid), 64'd0);
        check("rst_empty", 64'(o_alu_result_empty), 64'd0);
        check("rst_op", 64'(o_alu_output_op), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        i_rst_n = 1'b1;
        tick();
        check("idle_ready", 64'(o_req_ready), 64'd1);

        // plus cell already valid: minimum latency path
        cell_write(2'd0, 32'h5);
        sb.push_back('{5'd3, 32'h5, 5'b00000, 1'b0});
        request(2'd0, 5'd3);
        check("t1_busy", 64'(o_busy), 64'd1);
        wait_wb(n_empty);
        check("t1_empty_cycles", 64'(n_empty), 64'd2);
        cmp_wb("t1");
        handshake();
        check("t1_cell_cleared", 64'(cell_v[0]), 64'd0);

        // xor cell with writeback back-pressure
        cell_write(2'd3, 32'h8000_0000);
        sb.push_back('{5'd31, 32'h8000_0000, 5'b10010, 1'b0});
        request(2'd3, 5'd31);
        wait_wb(n_empty);
        hold_data  = o_wb_data;
        hold_flags = o_wb_flags;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 64'(o_wb_valid), 64'd1);
            check("t2_hold_data", 64'(o_wb_data), 64'h8000_0000);
            check("t2_hold_flags", 64'(o_wb_flags), 64'b10010);
        end
        cmp_wb("t2");
        handshake();
        check("t2_done_ready", 64'(o_req_ready), 64'd1);

        // and cell empty: timeout after 16 drain cycles
        sb.push_back('{5'd7, 32'd0, 5'd0, 1'b1});
        request(2'd1, 5'd7);
        wait_wb(n_empty);
        check("t3_drain_cycles", 64'(n_empty), 64'd16);
        cmp_wb("t3");
        handshake();

        // or cell written during drain cycle 4
        sb.push_back('{5'd12, 32'hF, 5'b00000, 1'b0});
        request(2'd2, 5'd12);
        tick();
        tick();
        tick();
        cell_write(2'd2, 32'hF);
        wait_wb(n_empty);
        cmp_wb("t4");
        handshake();

        // reset in drain cycle 1
        request(2'd1, 5'd2);
        check("t5_pre_empty", 64'(o_alu_result_empty), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_empty", 64'(o_alu_result_empty), 64'd0);
        check("t5_rst_busy", 64'(o_busy), 64'd0);
        check("t5_rst_wb_valid", 64'(o_wb_valid), 64'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("t5_ready", 64'(o_req_ready), 64'd1);

        // back-to-back with request valid held high
        cell_write(2'd0, 32'h1);
        cell_write(2'd3, 32'h2);
        sb.push_back('{5'd4, 32'h1, 5'b10000, 1'b0});
        sb.push_back('{5'd9, 32'h2, 5'b10000, 1'b0});
        i_req_valid = 1'b1;
        i_req_op    = 2'd0;
        i_req_dest  = 5'd4;
        tick();
        i_req_op    = 2'd3;
        i_req_dest  = 5'd9;
        check("t6_held_off", 64'(o_req_ready), 64'd0);
        wait_wb(n_empty);
        cmp_wb("t6a");
        handshake();
        check("t6_idle_after_hs", 64'(o_busy), 64'd0);
        tick();
        i_req_valid = 1'b0;
        check("t6_second_op", 64'(o_alu_output_op), 64'd3);
        wait_wb(n_empty);
        cmp_wb("t6b");
        handshake();
        check("t6_sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
